// File: rtl/voice_allocator.sv
// voice_allocator: shares VOICES note voices among one note-on/off event stream.
// Define VOICE_ALLOC_STEAL_EN to steal the oldest held voice when all are busy.
module voice_allocator #(
    parameter int VOICES = 4,
    parameter int AGE_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_on,
    input  logic [3:0]            ev_note,
    input  logic [2:0]            ev_octave,
    output logic [VOICES-1:0]     voice_note_in,
    output logic [4*VOICES-1:0]   voice_note,
    output logic [3*VOICES-1:0]   voice_octave,
    output logic [VOICES-1:0]     voice_gate,
    output logic                  steal_pulse
);

    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE
    } state_t;

    state_t                state_q, state_d;
    logic                  ev_on_q, ev_on_d;
    logic [3:0]            ev_note_q, ev_note_d;
    logic [2:0]            ev_oct_q, ev_oct_d;
    logic [4*VOICES-1:0]   note_q, note_d;
    logic [3*VOICES-1:0]   oct_q, oct_d;
    logic [VOICES-1:0]     gate_q, gate_d;
    logic [VOICES-1:0]     pulse_q, pulse_d;
    logic                  steal_q, steal_d;
    logic [AGE_W-1:0]      age_q [VOICES];
    logic [AGE_W-1:0]      age_d [VOICES];

    logic                  hit_found;
    logic                  free_found;
    logic [IDX_W-1:0]      hit_idx;
    logic [IDX_W-1:0]      free_idx;
    logic                  load;
    logic                  is_steal;
    logic [IDX_W-1:0]      tgt;
`ifdef VOICE_ALLOC_STEAL_EN
    logic                  old_found;
    logic [IDX_W-1:0]      old_idx;
    logic [AGE_W-1:0]      old_age;
`endif

    // Pick the target voice from the latched event and current gates/ages.
    always_comb begin
        hit_found  = 1'b0;
        free_found = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
`ifdef VOICE_ALLOC_STEAL_EN
        old_found  = 1'b0;
        old_idx    = '0;
        old_age    = '0;
`endif
        for (int k = 0; k < VOICES; k++) begin
            if (!hit_found && gate_q[k] &&
                note_q[4*k +: 4] == ev_note_q &&
                oct_q[3*k +: 3] == ev_oct_q) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(k);
            end
            if (!free_found && !gate_q[k]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(k);
            end
`ifdef VOICE_ALLOC_STEAL_EN
            if (gate_q[k] && (!old_found || age_q[k] > old_age)) begin
                old_found = 1'b1;
                old_idx   = IDX_W'(k);
                old_age   = age_q[k];
            end
`endif
        end
        load     = 1'b0;
        is_steal = 1'b0;
        tgt      = '0;
        if (hit_found) begin
            load = 1'b1;
            tgt  = hit_idx;
        end else if (free_found) begin
            load = 1'b1;
            tgt  = free_idx;
        end
`ifdef VOICE_ALLOC_STEAL_EN
        else begin
            load     = old_found;
            is_steal = old_found;
            tgt      = old_idx;
        end
`endif
    end

    // Sequencer and voice-state update; results become visible in ISSUE.
    always_comb begin
        state_d   = state_q;
        ev_on_d   = ev_on_q;
        ev_note_d = ev_note_q;
        ev_oct_d  = ev_oct_q;
        note_d    = note_q;
        oct_d     = oct_q;
        gate_d    = gate_q;
        age_d     = age_q;
        pulse_d   = '0;
        steal_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ev_valid) begin
                    ev_on_d   = ev_on;
                    ev_note_d = ev_note;
                    ev_oct_d  = ev_octave;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                state_d = S_ISSUE;
                if (ev_on_q && load) begin
                    for (int k = 0; k < VOICES; k++) begin
                        if (IDX_W'(k) == tgt) begin
                            note_d[4*k +: 4] = ev_note_q;
                            oct_d[3*k +: 3]  = ev_oct_q;
                            gate_d[k]        = 1'b1;
                            age_d[k]         = '0;
                            pulse_d[k]       = 1'b1;
                        end else if (gate_q[k] && age_q[k] != AGE_MAX) begin
                            age_d[k] = age_q[k] + AGE_W'(1);
                        end
                    end
                    steal_d = is_steal;
                end else if (!ev_on_q && hit_found) begin
                    gate_d[hit_idx] = 1'b0;
                end
            end
            S_ISSUE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ev_on_q   <= 1'b0;
            ev_note_q <= '0;
            ev_oct_q  <= '0;
            note_q    <= '0;
            oct_q     <= '0;
            gate_q    <= '0;
            pulse_q   <= '0;
            steal_q   <= 1'b0;
            for (int k = 0; k < VOICES; k++) begin
                age_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ev_on_q   <= ev_on_d;
            ev_note_q <= ev_note_d;
            ev_oct_q  <= ev_oct_d;
            note_q    <= note_d;
            oct_q     <= oct_d;
            gate_q    <= gate_d;
            pulse_q   <= pulse_d;
            steal_q   <= steal_d;
            age_q     <= age_d;
        end
    end

    assign ev_ready      = reset && (state_q == S_IDLE);
    assign voice_note_in = pulse_q;
    assign voice_note    = note_q;
    assign voice_octave  = oct_q;
    assign voice_gate    = gate_q;
    assign steal_pulse   = steal_q;

endmodule
